dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter and sequencer for the single-port 8-bit data memory (256 × 8 BRAM, one-cycle read latency). It shares the memory between the pipeline memory stage (primary) and a debug/loader port (secondary), drives the BRAM enable/write/address/data pins, returns read data with a valid strobe to the requester that issued it, and stalls the pipeline while the memory is busy.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive primary grants with secondary waiting before the secondary is forced in; used only with DMEM_ARB_STARVE_GUARD_EN.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- p_req  in  1  primary request, held until p_gnt
- p_we  in  1  primary write (1) / read (0)
- p_addr  in  8  primary address
- p_wdata  in  8  primary write data
- p_gnt  out  1  primary request issued to memory this cycle
- p_stall  out  1  p_req & ~p_gnt
- p_rdata  out  8  primary read data, registered
- p_rvalid  out  1  one-cycle strobe, p_rdata valid
- d_req, d_we, d_addr[8], d_wdata[8]  in  secondary request, same rules as primary
- d_gnt  out  1  secondary request issued this cycle
- d_rdata  out  8  secondary read data, registered
- d_rvalid  out  1  one-cycle strobe, d_rdata valid
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  8  BRAM address
- mem_din  out  8  BRAM write data
- mem_dout  in  8  BRAM read data, valid the cycle after a read is issued
- busy  out  1  high in RD_WAIT

## Operation

- FSM states: IDLE, RD_WAIT.
- IDLE: arbitrate among p_req/d_req. Winner's gnt high combinationally; mem_en=1, mem_we/addr/din from winner. Write: stays IDLE (next request accepted next cycle). Read: go to RD_WAIT, record owner (P or D).
- RD_WAIT: no grant issued, mem_en=0, busy=1. At end of cycle, mem_dout captured into owner's rdata; owner's rvalid high for the following cycle; return to IDLE.
- Priority: primary fixed-high. Secondary granted only when p_req=0 (unless starve guard fires).
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- rdata holds last value until the next read completes for that port; rvalid is high exactly one cycle per read.
- Simultaneous requests in IDLE: primary wins; secondary gnt=0 and secondary must hold.
- Request while in RD_WAIT: not granted; p_stall=1 if primary.
- Request dropped before grant: allowed, no side effect.

## Timing

- Write: accepted in grant cycle, memory updated at that edge; zero-latency completion.
- Read: grant cycle k, RD_WAIT cycle k+1, rvalid/rdata in cycle k+2. New grant possible in k+2 (rvalid and gnt may coincide).
- Read-to-read throughput: one read per 2 cycles; write-to-any: one per cycle.
- Reset (any state, including RD_WAIT): next cycle state=IDLE, p_rdata=d_rdata=0, p_rvalid=d_rvalid=0, busy=0, starve counter=0. While reset=1, p_gnt=d_gnt=0, mem_en=mem_we=0, mem_addr=mem_din=0; in-flight read data discarded, no rvalid.

## Configuration

- DMEM_ARB_STARVE_GUARD_EN defined: 3-bit counter increments on each primary grant while d_req=1; cleared on secondary grant or d_req=0. When counter = STARVE_LIMIT in IDLE with d_req=1, secondary wins over primary (primary stalls that cycle), counter clears.
- Not defined: pure fixed priority; secondary can starve indefinitely; no counter logic.

## Test plan

- Reset, then primary write addr 8'h10 data 8'hA5, then primary read 8'h10 -> p_gnt in both grant cycles, p_rvalid=1 with p_rdata=8'hA5 two cycles after read grant, d_rvalid stays 0.
- p_req and d_req both reading in same cycle -> p_gnt=1, d_gnt=0; secondary granted in primary's rvalid cycle; d_rdata returned 2 cycles later.
- Primary read then immediate primary read -> p_stall=1 during RD_WAIT, busy=1, second grant in first rvalid cycle.
- Assert reset during RD_WAIT -> no rvalid next cycle, rdata=0, state IDLE, mem_en=0.
- Guard on, STARVE_LIMIT=4, p_req and d_req held high (writes) -> grants P,P,P,P,D,P…; guard off -> d_gnt never asserts.
- Secondary write 8'hFF to 8'h00 with p_req low, then primary read 8'h00 -> p_rdata=8'hFF.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/response and BRAM pin bundle for dmem_arbiter.
// slave: arbiter side; master: requesters plus the BRAM model.
interface dmem_arbiter_if;
    logic       p_req;
    logic       p_we;
    logic [7:0] p_addr;
    logic [7:0] p_wdata;
    logic       p_gnt;
    logic       p_stall;
    logic [7:0] p_rdata;
    logic       p_rvalid;

    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_gnt;
    logic [7:0] d_rdata;
    logic       d_rvalid;

    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       busy;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_dout,
        output p_gnt, p_stall, p_rdata, p_rvalid, d_gnt, d_rdata, d_rvalid,
        output mem_en, mem_we, mem_addr, mem_din, busy
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  p_gnt, p_stall, p_rdata, p_rvalid, d_gnt, d_rdata, d_rvalid,
        input  mem_en, mem_we, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a 256x8 single-port BRAM between the pipeline (primary) and a debug port.
// Optional starvation guard for the debug port: `define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RD_WAIT = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          r_owner_d;
    logic          w_owner_nxt;
    logic [DW-1:0] r_p_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_p_rvalid;
    logic          r_d_rvalid;

    logic          w_idle;
    logic          w_force_d;
    logic          w_p_win;
    logic          w_d_win;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [CW-1:0] r_starve;

    assign w_force_d = (r_starve == CW'(STARVE_LIMIT)) && bus.d_req;

    // Counts primary grants the secondary has sat through
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_p_win && bus.d_req) begin
            r_starve <= CW'(r_starve + 1'b1);
        end else if (w_d_win || !bus.d_req) begin
            r_starve <= '0;
        end
    end
`else
    logic w_unused_starve_limit;

    assign w_force_d             = 1'b0;
    assign w_unused_starve_limit = ^CW'(STARVE_LIMIT);
`endif

    // Arbitration and BRAM pin drive; everything quiet during reset
    always_comb begin
        w_idle       = (r_state == S_IDLE) && !reset;
        w_p_win      = w_idle && bus.p_req && !w_force_d;
        w_d_win      = w_idle && bus.d_req && (!bus.p_req || w_force_d);
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        w_state_nxt  = S_IDLE;
        w_owner_nxt  = r_owner_d;
        if (w_p_win) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = bus.p_we;
            bus.mem_addr = AW'(bus.p_addr);
            bus.mem_din  = DW'(bus.p_wdata);
            if (!bus.p_we) begin
                w_state_nxt = S_RD_WAIT;
                w_owner_nxt = 1'b0;
            end
        end else if (w_d_win) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = bus.d_we;
            bus.mem_addr = AW'(bus.d_addr);
            bus.mem_din  = DW'(bus.d_wdata);
            if (!bus.d_we) begin
                w_state_nxt = S_RD_WAIT;
                w_owner_nxt = 1'b1;
            end
        end
    end

    assign bus.p_gnt    = w_p_win;
    assign bus.d_gnt    = w_d_win;
    assign bus.p_stall  = bus.p_req && !w_p_win;
    assign bus.busy     = (r_state == S_RD_WAIT);
    assign bus.p_rdata  = r_p_rdata;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.p_rvalid = r_p_rvalid;
    assign bus.d_rvalid = r_d_rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read return: BRAM output is valid during RD_WAIT, latched for the owner
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_d  <= 1'b0;
            r_p_rdata  <= '0;
            r_d_rdata  <= '0;
            r_p_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
        end else begin
            r_owner_d  <= w_owner_nxt;
            r_p_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            if (r_state == S_RD_WAIT) begin
                if (r_owner_d) begin
                    r_d_rdata  <= DW'(bus.mem_dout);
                    r_d_rvalid <= 1'b1;
                end else begin
                    r_p_rdata  <= DW'(bus.mem_dout);
                    r_p_rvalid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic
// against a transaction-level model of the memory and both ports.
module tb_dmem_arbiter;
    localparam int unsigned LIMIT = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk;
    logic reset;
    dmem_arbiter_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM: one-cycle registered read, write at the edge
    logic [7:0] bram [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout <= bram[bus.mem_addr];
        end
    end

    int vectors;
    int miscompares;
    int n_dgnt;

    // Reference model state
    logic [7:0] m_mem [256];
    bit         m_busy;
    bit         m_owner_d;
    logic [7:0] m_raddr;
    logic [7:0] m_prd, m_drd;
    bit         m_pv, m_dv;
    int         m_cnt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst,
                       input logic pr, input logic pw, input logic [7:0] pa, input logic [7:0] pd,
                       input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd);
        bit force_d, e_pg, e_dg;
        logic e_we;
        logic [7:0] e_addr, e_din;
        @(negedge clk);
        reset = rst;
        bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
        #1;
        force_d = GUARD && (m_cnt == int'(LIMIT)) && dr;
        e_pg = !rst && !m_busy && pr && !force_d;
        e_dg = !rst && !m_busy && dr && (!pr || force_d);
        e_we   = e_pg ? pw : (e_dg ? dw : 1'b0);
        e_addr = e_pg ? pa : (e_dg ? da : 8'h00);
        e_din  = e_pg ? pd : (e_dg ? dd : 8'h00);
        chk("p_gnt",    8'(bus.p_gnt),    8'(e_pg));
        chk("d_gnt",    8'(bus.d_gnt),    8'(e_dg));
        chk("p_stall",  8'(bus.p_stall),  8'(pr && !e_pg));
        chk("busy",     8'(bus.busy),     8'(m_busy));
        chk("mem_en",   8'(bus.mem_en),   8'(e_pg || e_dg));
        chk("mem_we",   8'(bus.mem_we),   8'(e_we));
        chk("mem_addr", bus.mem_addr,     e_addr);
        chk("mem_din",  bus.mem_din,      e_din);
        chk("p_rvalid", 8'(bus.p_rvalid), 8'(m_pv));
        chk("p_rdata",  bus.p_rdata,      m_prd);
        chk("d_rvalid", 8'(bus.d_rvalid), 8'(m_dv));
        chk("d_rdata",  bus.d_rdata,      m_drd);
        if (bus.d_gnt === 1'b1) n_dgnt++;
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_pv = 1'b0; m_dv = 1'b0;
            m_prd = 8'h00; m_drd = 8'h00; m_cnt = 0;
        end else begin
            m_pv = 1'b0; m_dv = 1'b0;
            if (m_busy) begin
                if (m_owner_d) begin m_drd = m_mem[m_raddr]; m_dv = 1'b1; end
                else           begin m_prd = m_mem[m_raddr]; m_pv = 1'b1; end
                m_busy = 1'b0;
            end
            if (e_pg) begin
                if (pw) m_mem[pa] = pd;
                else begin m_busy = 1'b1; m_owner_d = 1'b0; m_raddr = pa; end
            end else if (e_dg) begin
                if (dw) m_mem[da] = dd;
                else begin m_busy = 1'b1; m_owner_d = 1'b1; m_raddr = da; end
            end
            if (e_pg && dr)         m_cnt = m_cnt + 1;
            else if (e_dg || !dr)   m_cnt = 0;
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        vectors = 0; miscompares = 0; n_dgnt = 0;
        for (int i = 0; i < 256; i++) begin bram[i] = 8'h00; m_mem[i] = 8'h00; end
        m_busy = 1'b0; m_owner_d = 1'b0; m_raddr = 8'h00;
        m_prd = 8'h00; m_drd = 8'h00; m_pv = 1'b0; m_dv = 1'b0; m_cnt = 0;
        reset = 1'b1;
        bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = 8'h00; bus.p_wdata = 8'h00;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;

        cyc(1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 8'h55, 8'h66);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        // Primary write then read back
        cyc(1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        idle();
        #1;
        chk("wr_rd_p_rvalid", 8'(bus.p_rvalid), 8'h01);
        chk("wr_rd_p_rdata",  bus.p_rdata,      8'hA5);
        chk("wr_rd_d_rvalid", 8'(bus.d_rvalid), 8'h00);

        // Simultaneous reads: primary first, secondary in primary's rvalid cycle
        cyc(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
        idle();
        #1;
        chk("dual_d_rvalid", 8'(bus.d_rvalid), 8'h01);
        chk("dual_d_rdata",  bus.d_rdata,      8'hA5);

        // Back-to-back primary reads stall through RD_WAIT
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        idle();

        // Reset while a read is in flight
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rst_rdwait_p_rvalid", 8'(bus.p_rvalid), 8'h00);
        chk("rst_rdwait_p_rdata",  bus.p_rdata,      8'h00);
        chk("rst_rdwait_busy",     8'(bus.busy),     8'h00);
        idle();

        // Secondary write, primary reads it back
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        idle();
        #1;
        chk("d_wr_p_rd_rdata", bus.p_rdata, 8'hFF);

        // Both ports hammering writes: guard lets secondary in every LIMIT+1 cycles
        idle();
        n_dgnt = 0;
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b1, 1'b1, 8'(8'h40 + i), 8'(i), 1'b1, 1'b1, 8'(8'h80 + i), 8'(8'hC0 + i));
        chk("starve_d_gnt_count", 8'(n_dgnt), GUARD ? 8'd2 : 8'd0);

        // Random traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
